branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- IF-stage next-PC predictor that sits directly upstream of the pipelined datapath.
- Each cycle it maps the fetch PC to a predicted next PC using a direct-mapped BTB plus per-entry 2-bit saturating counters.
- It is trained by branch/jump resolution from the ID stage, flags mispredicts, and owns the num_branch / num_branch_miss statistics consumed by the CPU top.

Parameters:
- WORD_SIZE, 16, width of PCs, targets and statistics counters.
- BTB_INDEX_BITS, 4, log2 of entry count (16 entries); index = pc[BTB_INDEX_BITS-1:0], tag = pc[WORD_SIZE-1:BTB_INDEX_BITS].
- PREDICT_MODE, 2, prediction policy:
  - 0: always not-taken (pc+1).
  - 1: taken on any valid BTB hit.
  - 2: 2-bit counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- if_pc  input  WORD_SIZE  PC currently being fetched.
- predicted_pc  output  WORD_SIZE  predicted next fetch PC (combinational).
- predict_taken  output  1  high when predicted_pc is the BTB target (combinational).
- update_en  input  1  one-cycle pulse: a control-flow instruction resolved in ID.
- update_pc  input  WORD_SIZE  PC of the resolved instruction.
- update_is_jump  input  1  unconditional (J/JAL/JR/JALR) vs conditional branch.
- update_taken  input  1  actual direction.
- update_target  input  WORD_SIZE  actual target when taken.
- update_pred_pc  input  WORD_SIZE  predicted_pc that was issued for update_pc (carried down the pipe).
- mispredict  output  1  combinational: update_en && (actual next PC != update_pred_pc).
- num_branch  output  WORD_SIZE  count of update_en pulses.
- num_branch_miss  output  WORD_SIZE  count of mispredicts.

Behaviour:
- Reset (reset_n=0 at posedge):
  - All valid bits cleared.
  - All counters set to WNT (01).
  - num_branch and num_branch_miss set to 0.
  - Any update_en in that cycle is ignored.
  - predicted_pc = if_pc+1 and predict_taken = 0 while table is empty.
- Lookup (zero latency, combinational):
  - hit = valid[idx] && tag[idx] == if_pc tag.
  - predict_taken is:
    - mode 0: 0.
    - mode 1: hit.
    - mode 2: hit && ctr[idx][1].
  - predicted_pc = predict_taken ? target[idx] : if_pc+1, with pc+1 wrapping modulo 2^WORD_SIZE.
- Actual next PC = update_taken ? update_target : update_pc+1.
- mispredict: computed only while update_en; it is 0 otherwise.
- Training (posedge, update_en && reset_n), with uhit = tag match at update_pc index:
  - Taken, uhit: target rewritten; ctr saturating increment (11 stays 11).
  - Taken, no uhit: allocate — valid=1, tag, target written; ctr=WT (10), or ST (11) if update_is_jump.
  - Not taken, uhit: ctr saturating decrement (00 stays 00).
  - Not taken, no uhit: no change (no allocation).
  - update_is_jump: always treated as taken; ctr forced to 11.
- Statistics:
  - num_branch +1 per update_en.
  - num_branch_miss +1 when mispredict.
  - Both wrap at 2^WORD_SIZE.
- Same-cycle lookup and update at the same index: lookup sees pre-update contents; the new entry is visible from the next cycle.
- Table state is not gated by pipeline stalls. The datapath pulses update_en exactly once per resolved instruction, never on stalled or flushed slots.
- Aliasing:
  - Different tag at same index: treated as a miss.
  - Taken-allocation evicts the old entry, with no read-modify of the old counter.

Decomposition:
- constants.v gets:
  - BTB_INDEX_BITS default.
  - Counter encodings CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11.
  - PREDICT_MODE codes.
- One natural sub-module: bp_sat_counter (2-bit next-state function: inc/dec/force-set). Instantiated once on the update path only; the storage array stays in branch_predictor.

Test Plan:
- Reset then if_pc=0x0010 → predicted_pc=0x0011, predict_taken=0, num_branch=0, num_branch_miss=0.
- Branch at pc=0x0020:
  - Update taken with target 0x0040, update_pred_pc=0x0021 → mispredict=1, counts 1/1.
  - Next cycle if_pc=0x0020 → predicted_pc=0x0040, predict_taken=1.
- Same branch not-taken twice after allocation (WT→WNT→SNT) → if_pc=0x0020 predicts 0x0021; a third not-taken keeps ctr=00. Mode 1 instead predicts 0x0040.
- JAL at pc=0x0005, target 0x0100 → entry ctr=11. Conflicting pc=0x0015 (same index 5) taken to 0x0200 evicts it → if_pc=0x0005 predicts 0x0006.
- Update of index 3 in the same cycle as lookup of pc=0x0003 → lookup returns old value; new target seen the following cycle.
- update_en asserted together with reset_n=0 → no allocation and counters remain 0. Also: 65536 updates → num_branch wraps to 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared constants for the IF-stage next-PC predictor: counter encodings,
// prediction policy codes and default geometry.
package branch_predictor_pkg;

    localparam int WORD_SIZE_DEF      = 16;
    localparam int BTB_INDEX_BITS_DEF = 4;

    localparam int PM_NOT_TAKEN = 0;
    localparam int PM_BTB_HIT   = 1;
    localparam int PM_TWO_BIT   = 2;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state function with a force-to-strongly-taken
// override; purely combinational.
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  ctr_e ctr_i,
    input  logic inc_i,
    input  logic dec_i,
    input  logic force_set_i,
    output ctr_e ctr_o
);

    // NOTE: default assigned first so no path through the block leaves ctr_o
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        ctr_o = ctr_i;
        if (force_set_i) begin
            ctr_o = CTR_ST;
        end else if (inc_i && (ctr_i != CTR_ST)) begin
            ctr_o = ctr_e'(ctr_i + 2'd1);
        end else if (dec_i && (ctr_i != CTR_SNT)) begin
            ctr_o = ctr_e'(ctr_i - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit counters: zero-latency next-PC lookup,
// training from ID-stage resolution, mispredict flag and branch statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int WORD_SIZE      = WORD_SIZE_DEF,
    parameter int BTB_INDEX_BITS = BTB_INDEX_BITS_DEF,
    parameter int PREDICT_MODE   = PM_TWO_BIT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] if_pc,
    output logic [WORD_SIZE-1:0] predicted_pc,
    output logic                 predict_taken,
    input  logic                 update_en,
    input  logic [WORD_SIZE-1:0] update_pc,
    input  logic                 update_is_jump,
    input  logic                 update_taken,
    input  logic [WORD_SIZE-1:0] update_target,
    input  logic [WORD_SIZE-1:0] update_pred_pc,
    output logic                 mispredict,
    output logic [WORD_SIZE-1:0] num_branch,
    output logic [WORD_SIZE-1:0] num_branch_miss
);

    localparam int ENTRIES = 1 << BTB_INDEX_BITS;
    localparam int TAG_W   = WORD_SIZE - BTB_INDEX_BITS;

    logic                 valid_q  [ENTRIES];
    ctr_e                 ctr_q    [ENTRIES];
    logic [TAG_W-1:0]     tag_q    [ENTRIES];
    logic [WORD_SIZE-1:0] target_q [ENTRIES];

    logic [WORD_SIZE-1:0] num_branch_q, num_branch_d;
    logic [WORD_SIZE-1:0] num_miss_q, num_miss_d;

    // Lookup
    logic [BTB_INDEX_BITS-1:0] if_idx;
    logic [TAG_W-1:0]          if_tag;
    logic                      hit;

    assign if_idx = if_pc[BTB_INDEX_BITS-1:0];
    assign if_tag = if_pc[WORD_SIZE-1:BTB_INDEX_BITS];
    assign hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    always_comb begin
        predict_taken = 1'b0;
        case (PREDICT_MODE)
            PM_BTB_HIT: predict_taken = hit;
            PM_TWO_BIT: predict_taken = hit && ctr_q[if_idx][1];
            default:    predict_taken = 1'b0;
        endcase
    end

    assign predicted_pc = predict_taken ? target_q[if_idx] : if_pc + WORD_SIZE'(1);

    // Resolution and training
    logic [BTB_INDEX_BITS-1:0] upd_idx;
    logic [TAG_W-1:0]          upd_tag;
    logic                      upd_hit;
    logic                      upd_taken_eff;
    logic [WORD_SIZE-1:0]      actual_next_pc;
    ctr_e                      ctr_cur;
    ctr_e                      ctr_next;

    assign upd_idx        = update_pc[BTB_INDEX_BITS-1:0];
    assign upd_tag        = update_pc[WORD_SIZE-1:BTB_INDEX_BITS];
    assign upd_hit        = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_taken_eff  = update_taken || update_is_jump;
    assign actual_next_pc = update_taken ? update_target : update_pc + WORD_SIZE'(1);
    assign mispredict     = update_en && (actual_next_pc != update_pred_pc);

    // A fresh allocation is modelled as an increment from WNT, landing on WT.
    assign ctr_cur = upd_hit ? ctr_q[upd_idx] : CTR_WNT;

    bp_sat_counter u_sat_counter (
        .ctr_i       (ctr_cur),
        .inc_i       (update_taken),
        .dec_i       (!update_taken),
        .force_set_i (update_is_jump),
        .ctr_o       (ctr_next)
    );

    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values, matching the flop behaviour in synthesis.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else if (update_en) begin
            if (upd_taken_eff) begin
                valid_q[upd_idx] <= 1'b1;
                ctr_q[upd_idx]   <= ctr_next;
            end else if (upd_hit) begin
                ctr_q[upd_idx]   <= ctr_next;
            end
        end
    end

    // NOTE: tag and target arrays carry no reset; the cleared valid bits make
    // their contents irrelevant and keep them mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (reset_n && update_en && upd_taken_eff) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= update_target;
        end
    end

    // Statistics
    always_comb begin
        num_branch_d = num_branch_q;
        num_miss_d   = num_miss_q;
        if (update_en) begin
            num_branch_d = num_branch_q + WORD_SIZE'(1);
        end
        if (mispredict) begin
            num_miss_d = num_miss_q + WORD_SIZE'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            num_branch_q <= '0;
            num_miss_q   <= '0;
        end else begin
            num_branch_q <= num_branch_d;
            num_miss_q   <= num_miss_d;
        end
    end

    assign num_branch      = num_branch_q;
    assign num_branch_miss = num_miss_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor; a mode-1 copy shares the
// same stimulus to contrast hit-only prediction with the 2-bit counter policy.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] if_pc;
    logic        update_en;
    logic [15:0] update_pc;
    logic        update_is_jump;
    logic        update_taken;
    logic [15:0] update_target;
    logic [15:0] update_pred_pc;

    logic [15:0] predicted_pc, num_branch, num_branch_miss;
    logic        predict_taken, mispredict;
    logic [15:0] m1_predicted_pc, m1_num_branch, m1_num_branch_miss;
    logic        m1_predict_taken, m1_mispredict;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    branch_predictor #(.WORD_SIZE(16), .BTB_INDEX_BITS(4), .PREDICT_MODE(2)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .if_pc           (if_pc),
        .predicted_pc    (predicted_pc),
        .predict_taken   (predict_taken),
        .update_en       (update_en),
        .update_pc       (update_pc),
        .update_is_jump  (update_is_jump),
        .update_taken    (update_taken),
        .update_target   (update_target),
        .update_pred_pc  (update_pred_pc),
        .mispredict      (mispredict),
        .num_branch      (num_branch),
        .num_branch_miss (num_branch_miss)
    );

    branch_predictor #(.WORD_SIZE(16), .BTB_INDEX_BITS(4), .PREDICT_MODE(1)) dut_m1 (
        .clk             (clk),
        .reset_n         (reset_n),
        .if_pc           (if_pc),
        .predicted_pc    (m1_predicted_pc),
        .predict_taken   (m1_predict_taken),
        .update_en       (update_en),
        .update_pc       (update_pc),
        .update_is_jump  (update_is_jump),
        .update_taken    (update_taken),
        .update_target   (update_target),
        .update_pred_pc  (update_pred_pc),
        .mispredict      (m1_mispredict),
        .num_branch      (m1_num_branch),
        .num_branch_miss (m1_num_branch_miss)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic en, input logic [15:0] pc, input logic jump,
                           input logic taken, input logic [15:0] tgt, input logic [15:0] pred);
        update_en      = en;
        update_pc      = pc;
        update_is_jump = jump;
        update_taken   = taken;
        update_target  = tgt;
        update_pred_pc = pred;
    endtask

    task automatic look(input logic [15:0] pc);
        if_pc = pc;
        #1;
    endtask

    initial begin
        // Reset with a concurrent update that must be ignored
        reset_n = 1'b0;
        if_pc   = 16'h0010;
        set_upd(1'b1, 16'h0030, 1'b0, 1'b1, 16'h0099, 16'h0031);
        tick();
        reset_n = 1'b1;
        set_upd(1'b0, 16'h0030, 1'b0, 1'b1, 16'h0099, 16'h0031);
        look(16'h0010);
        check("rst_pred_pc", predicted_pc, 16'h0011);
        check("rst_taken", {15'd0, predict_taken}, 16'h0000);
        check("rst_nbr", num_branch, 16'h0000);
        check("rst_nmiss", num_branch_miss, 16'h0000);
        check("rst_idle_misp", {15'd0, mispredict}, 16'h0000);
        look(16'h0030);
        check("rst_no_alloc", predicted_pc, 16'h0031);
        check("rst_no_alloc_m1", m1_predicted_pc, 16'h0031);
        look(16'hFFFF);
        check("pc_wrap", predicted_pc, 16'h0000);

        // Taken branch at 0x20 allocates with WT
        set_upd(1'b1, 16'h0020, 1'b0, 1'b1, 16'h0040, 16'h0021);
        look(16'h0020);
        check("alloc_misp", {15'd0, mispredict}, 16'h0001);
        check("alloc_same_cycle", predicted_pc, 16'h0021);
        tick();
        set_upd(1'b0, 16'h0020, 1'b0, 1'b0, 16'h0040, 16'h0021);
        look(16'h0020);
        check("alloc_nbr", num_branch, 16'h0001);
        check("alloc_nmiss", num_branch_miss, 16'h0001);
        check("alloc_pred_pc", predicted_pc, 16'h0040);
        check("alloc_taken", {15'd0, predict_taken}, 16'h0001);

        // Not-taken: WT -> WNT
        set_upd(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0040, 16'h0040);
        #1;
        check("nt1_misp", {15'd0, mispredict}, 16'h0001);
        tick();
        check("nt1_pred_pc", predicted_pc, 16'h0021);
        // Not-taken: WNT -> SNT, predicted correctly
        set_upd(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0040, 16'h0021);
        #1;
        check("nt2_misp", {15'd0, mispredict}, 16'h0000);
        tick();
        check("nt2_pred_pc", predicted_pc, 16'h0021);
        check("nt2_m1_pred_pc", m1_predicted_pc, 16'h0040);
        // Third not-taken saturates at SNT
        tick();
        check("nt3_nbr", num_branch, 16'h0004);
        check("nt3_nmiss", num_branch_miss, 16'h0002);
        // Taken from SNT -> WNT still predicts fall-through
        set_upd(1'b1, 16'h0020, 1'b0, 1'b1, 16'h0040, 16'h0021);
        tick();
        check("sat_lo_pred_pc", predicted_pc, 16'h0021);
        // Taken again WNT -> WT predicts target
        tick();
        check("sat_up_pred_pc", predicted_pc, 16'h0040);
        check("sat_up_nbr", num_branch, 16'h0006);
        check("sat_up_nmiss", num_branch_miss, 16'h0004);

        // JAL at 0x05 forces ST; one not-taken leaves it taken
        set_upd(1'b1, 16'h0005, 1'b1, 1'b1, 16'h0100, 16'h0006);
        look(16'h0005);
        tick();
        check("jal_pred_pc", predicted_pc, 16'h0100);
        set_upd(1'b1, 16'h0005, 1'b0, 1'b0, 16'h0100, 16'h0100);
        tick();
        check("jal_st_pred_pc", predicted_pc, 16'h0100);
        // Conflicting 0x15 evicts index 5
        set_upd(1'b1, 16'h0015, 1'b0, 1'b1, 16'h0200, 16'h0016);
        tick();
        set_upd(1'b0, 16'h0015, 1'b0, 1'b0, 16'h0200, 16'h0016);
        look(16'h0005);
        check("evict_old_pc", predicted_pc, 16'h0006);
        check("evict_old_taken", {15'd0, predict_taken}, 16'h0000);
        look(16'h0015);
        check("evict_new_pc", predicted_pc, 16'h0200);
        check("evict_nbr", num_branch, 16'h0009);
        check("evict_nmiss", num_branch_miss, 16'h0007);

        // Same-cycle lookup and update at index 3
        set_upd(1'b1, 16'h0003, 1'b0, 1'b1, 16'h0300, 16'h0004);
        look(16'h0003);
        tick();
        set_upd(1'b1, 16'h0003, 1'b0, 1'b1, 16'h0333, 16'h0300);
        #1;
        check("bypass_old", predicted_pc, 16'h0300);
        check("bypass_misp", {15'd0, mispredict}, 16'h0001);
        tick();
        set_upd(1'b0, 16'h0003, 1'b0, 1'b0, 16'h0333, 16'h0300);
        #1;
        check("bypass_new", predicted_pc, 16'h0333);
        check("bypass_nbr", num_branch, 16'h000B);
        check("bypass_nmiss", num_branch_miss, 16'h0009);

        // Statistics wrap after 65536 updates
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        set_upd(1'b1, 16'h0020, 1'b0, 1'b1, 16'h0040, 16'h0040);
        repeat (65535) tick();
        check("wrap_pre_nbr", num_branch, 16'hFFFF);
        check("wrap_pre_nmiss", num_branch_miss, 16'h0000);
        tick();
        set_upd(1'b0, 16'h0020, 1'b0, 1'b0, 16'h0040, 16'h0040);
        #1;
        check("wrap_nbr", num_branch, 16'h0000);
        check("wrap_m1_nbr", m1_num_branch, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
